core_pmp_checker: RTL

//  Multi-cycle, parametrised PMP checker with priority resolution and valid/ready handshakes.

---
 rtl/core_pmp_checker_if.sv | 31 +++
 rtl/core_pmp_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_pmp_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_pmp_checker_if
//  Description : Check-request / response handshake bundle for core_pmp_checker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_pmp_checker_if #(
  parameter int ADDR_WIDTH = 56
);
  logic                  chk_valid;
  logic                  chk_ready;
  logic [ADDR_WIDTH-1:0] chk_addr;
  logic [1:0]            chk_prv;
  logic [2:0]            chk_acc;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_hit;
  logic                  rsp_fault;
  logic [5:0]            rsp_region;

  modport master (
    output chk_valid, chk_addr, chk_prv, chk_acc, rsp_ready,
    input  chk_ready, rsp_valid, rsp_hit, rsp_fault, rsp_region
  );

  modport slave (
    input  chk_valid, chk_addr, chk_prv, chk_acc, rsp_ready,
    output chk_ready, rsp_valid, rsp_hit, rsp_fault, rsp_region
  );
endinterface
`default_nettype wire

// File: rtl/core_pmp_checker.sv
`default_nettype none
// ============================================================================
//  Module      : core_pmp_checker
//  Description : Multi-cycle PMP checker holding pmpcfg/pmpaddr, scanning LANES
//                regions per beat with lowest-index priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_pmp_checker #(
  parameter int ADDR_WIDTH  = 56,
  parameter int NUM_REGIONS = 16,
  parameter int LANES       = 4,
  parameter bit EN_TOR      = 1'b1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  core_pmp_checker_if.slave chk,
  input  logic              csr_en,
  input  logic              csr_wr,
  input  logic              csr_wr_set,
  input  logic              csr_wr_clr,
  input  logic [11:0]       csr_addr,
  input  logic [63:0]       csr_wdata,
  output logic [63:0]       csr_rdata,
  output logic              csr_error,
  output logic              csr_stall
);

  localparam int c_BEATS  = NUM_REGIONS / LANES;
  localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
  localparam int c_PA_W   = ADDR_WIDTH - 2;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_SCAN = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  localparam logic [1:0] c_A_OFF   = 2'd0;
  localparam logic [1:0] c_A_TOR   = 2'd1;
  localparam logic [1:0] c_A_NA4   = 2'd2;
  localparam logic [1:0] c_A_NAPOT = 2'd3;
  localparam logic [1:0] c_PRV_M   = 2'b10;

  // CSR state
  logic [7:0]        r_cfg     [NUM_REGIONS];
  logic [c_PA_W-1:0] r_pmpaddr [NUM_REGIONS];

  // Check pipeline state
  logic [1:0]         r_state;
  logic [c_BEAT_W-1:0] r_beat;
  logic [c_PA_W-1:0]  r_pa;
  logic [1:0]         r_prv;
  logic [2:0]         r_acc;
  logic               r_hit;
  logic               r_fault;
  logic [5:0]         r_region;

  logic [c_PA_W-1:0]  w_base      [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] w_addr_lock;
  logic [NUM_REGIONS-1:0] w_cfg_we;
  logic [NUM_REGIONS-1:0] w_addr_we;
  logic [7:0]         w_cfg_new   [NUM_REGIONS];

  logic               w_any_wr;
  logic               w_csr_do;
  logic               w_in_cfg_range;
  logic               w_is_cfg;
  logic               w_is_addr;
  logic [2:0]         w_cfg_sel;
  logic [5:0]         w_addr_idx;
  logic [63:0]        w_rdata;
  logic [63:0]        w_csr_new;

  logic [7:0]         w_lane_cfg  [LANES];
  logic [c_PA_W-1:0]  w_lane_top  [LANES];
  logic [c_PA_W-1:0]  w_lane_base [LANES];
  logic [LANES-1:0]   w_lane_hit;
  logic               w_scan_hit;
  logic [5:0]         w_scan_region;
  logic [7:0]         w_scan_cfg;
  logic               w_is_m;
  logic               w_fault;
  logic               w_unused;

  function automatic logic [7:0] f_legal_cfg(input logic [7:0] v);
    logic [7:0] o;
    o      = v;
    o[6:5] = 2'b00;
    if (!o[0]) o[1] = 1'b0;
    if (!EN_TOR && (o[4:3] == c_A_TOR)) o[4:3] = c_A_OFF;
    return o;
  endfunction

  // ---------------------------------------------------------------- CSR decode
  assign w_any_wr       = csr_wr | csr_wr_set | csr_wr_clr;
  assign w_in_cfg_range = (csr_addr[11:4] == 8'h3A);
  assign w_is_cfg       = w_in_cfg_range & ~csr_addr[0];
  assign w_cfg_sel      = csr_addr[3:1];
  assign w_is_addr      = (csr_addr >= 12'h3B0) && (csr_addr <= 12'h3EF);
  assign w_addr_idx     = 6'(csr_addr - 12'h3B0);
  // Set/clear modify state as well, so they are refused while busy like plain writes
  assign csr_stall      = csr_en & w_any_wr & (r_state != c_ST_IDLE);
  assign w_csr_do       = csr_en & w_any_wr & (r_state == c_ST_IDLE);
  assign csr_error      = csr_en & ~(w_in_cfg_range | w_is_addr);
  assign csr_rdata      = w_rdata;

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (w_is_cfg && (w_cfg_sel == 3'(i / 8))) w_rdata[(i % 8) * 8 +: 8] = r_cfg[i];
      if (w_is_addr && (w_addr_idx == 6'(i)))   w_rdata = 64'(r_pmpaddr[i]);
    end
  end

  always_comb begin
    w_csr_new = w_rdata;
    if (csr_wr)          w_csr_new = csr_wdata;
    else if (csr_wr_set) w_csr_new = w_rdata | csr_wdata;
    else if (csr_wr_clr) w_csr_new = w_rdata & ~csr_wdata;
  end

  for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
    if (i == 0) begin : g_base_zero
      assign w_base[i] = '0;
    end else begin : g_base_prev
      assign w_base[i] = r_pmpaddr[i-1];
    end
    // A locked TOR region above also freezes this region's address (its base)
    if (i == NUM_REGIONS - 1) begin : g_lock_last
      assign w_addr_lock[i] = r_cfg[i][7];
    end else begin : g_lock_tor
      assign w_addr_lock[i] = r_cfg[i][7] | (r_cfg[i+1][7] & (r_cfg[i+1][4:3] == c_A_TOR));
    end
    assign w_cfg_we[i]  = w_csr_do & w_is_cfg & (w_cfg_sel == 3'(i / 8)) & ~r_cfg[i][7];
    assign w_addr_we[i] = w_csr_do & w_is_addr & (w_addr_idx == 6'(i)) & ~w_addr_lock[i];
    assign w_cfg_new[i] = f_legal_cfg(w_csr_new[(i % 8) * 8 +: 8]);
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        r_cfg[i]     <= '0;
        r_pmpaddr[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGIONS; i++) begin
        if (w_cfg_we[i])  r_cfg[i]     <= w_cfg_new[i];
        if (w_addr_we[i]) r_pmpaddr[i] <= w_csr_new[c_PA_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------- lane scan
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_cfg[l]  = '0;
      w_lane_top[l]  = '0;
      w_lane_base[l] = '0;
      for (int b = 0; b < c_BEATS; b++) begin
        if (r_beat == c_BEAT_W'(b)) begin
          w_lane_cfg[l]  = r_cfg[b * LANES + l];
          w_lane_top[l]  = r_pmpaddr[b * LANES + l];
          w_lane_base[l] = w_base[b * LANES + l];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [c_PA_W-1:0] w_napot_mask;
    assign w_napot_mask  = ~(w_lane_top[l] ^ (w_lane_top[l] + c_PA_W'(1)));
    assign w_lane_hit[l] =
      (w_lane_cfg[l][4:3] == c_A_TOR)   ? ((r_pa >= w_lane_base[l]) && (r_pa < w_lane_top[l])) :
      (w_lane_cfg[l][4:3] == c_A_NA4)   ? (r_pa == w_lane_top[l]) :
      (w_lane_cfg[l][4:3] == c_A_NAPOT) ? ((r_pa & w_napot_mask) == (w_lane_top[l] & w_napot_mask)) :
                                          1'b0;
  end

  assign w_scan_hit = |w_lane_hit;

  always_comb begin
    w_scan_region = '0;
    w_scan_cfg    = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_lane_hit[l]) begin
        w_scan_region = 6'(int'(r_beat) * LANES + l);
        w_scan_cfg    = w_lane_cfg[l];
      end
    end
  end

  // M-mode bypasses unlocked regions; everything else needs the permission bit
  assign w_is_m  = (r_prv == c_PRV_M);
  assign w_fault = !w_scan_hit                 ? ~w_is_m :
                   (w_is_m && !w_scan_cfg[7])  ? 1'b0 :
                                                 ~|(r_acc & w_scan_cfg[2:0]);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state  <= c_ST_IDLE;
      r_beat   <= '0;
      r_pa     <= '0;
      r_prv    <= '0;
      r_acc    <= '0;
      r_hit    <= 1'b0;
      r_fault  <= 1'b0;
      r_region <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (chk.chk_valid) begin
            r_state <= c_ST_SCAN;
            r_beat  <= '0;
            r_pa    <= chk.chk_addr[ADDR_WIDTH-1:2];
            r_prv   <= chk.chk_prv;
            r_acc   <= chk.chk_acc;
          end
        end
        c_ST_SCAN: begin
          if (w_scan_hit || (r_beat == c_BEAT_W'(c_BEATS - 1))) begin
            r_state  <= c_ST_RESP;
            r_hit    <= w_scan_hit;
            r_fault  <= w_fault;
            r_region <= w_scan_region;
          end else begin
            r_beat <= r_beat + c_BEAT_W'(1);
          end
        end
        c_ST_RESP: begin
          if (chk.rsp_ready) r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign chk.chk_ready  = (r_state == c_ST_IDLE);
  assign chk.rsp_valid  = (r_state == c_ST_RESP);
  assign chk.rsp_hit    = r_hit;
  assign chk.rsp_fault  = r_fault;
  assign chk.rsp_region = r_region;

  assign w_unused = ^{chk.chk_addr[1:0], w_scan_cfg[6:3]};

endmodule
`default_nettype wire
